// File: rtl/uart_mode_receiver.sv
`default_nettype none
// ============================================================================
// uart_mode_receiver : 8N1 UART front end that parses {HEADER, mode, checksum}
// frames and drives a held operating-mode byte to the LCD controller.
// Revision: 1.0
// ============================================================================
module uart_mode_receiver #(
    parameter int unsigned CLK_FREQ     = 50000000,
    parameter int unsigned BAUD         = 9600,
    parameter logic [7:0]  HEADER       = 8'hAA,
    parameter logic [7:0]  DEFAULT_MODE = 8'h00
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] modo_operacao,
    output logic       mode_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int unsigned      CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned      CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST    = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        P_WAIT_HDR  = 2'd0,
        P_WAIT_MODE = 2'd1,
        P_WAIT_CHK  = 2'd2
    } p_state_t;

    // Synchronizer presets to the idle (high) level so reset never fakes a start bit
    logic sync1_q;
    logic sync2_q;
    logic rxs;

    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] clk_cnt_q,  clk_cnt_d;
    logic [2:0]       bit_cnt_q,  bit_cnt_d;
    logic [7:0]       shift_q,    shift_d;
    logic             byte_stb;
    logic             stop_err;

    p_state_t         p_state_q,    p_state_d;
    logic [7:0]       held_q,       held_d;
    logic [7:0]       mode_q,       mode_d;
    logic             mode_valid_q, mode_valid_d;
    logic             frame_err_q,  frame_err_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    assign rxs = sync2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_q <= RX_IDLE;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        byte_stb   = 1'b0;
        stop_err   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                clk_cnt_d = '0;
                if (!rxs) begin
                    bit_cnt_d  = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                // Mid-start-bit check rejects short glitches without an error
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d  = '0;
                    rx_state_d = rxs ? RX_IDLE : RX_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    shift_d   = {rxs, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d  = '0;
                    rx_state_d = RX_IDLE;
                    if (rxs) begin
                        byte_stb = 1'b1;
                    end else begin
                        stop_err = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
                clk_cnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_state_q    <= P_WAIT_HDR;
            held_q       <= '0;
            mode_q       <= DEFAULT_MODE;
            mode_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            p_state_q    <= p_state_d;
            held_q       <= held_d;
            mode_q       <= mode_d;
            mode_valid_q <= mode_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // The completed byte sits in shift_q during the strobe cycle
    always_comb begin
        p_state_d    = p_state_q;
        held_d       = held_q;
        mode_d       = mode_q;
        mode_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        if (stop_err) begin
            p_state_d   = P_WAIT_HDR;
            frame_err_d = 1'b1;
        end else if (byte_stb) begin
            case (p_state_q)
                P_WAIT_HDR: begin
                    if (shift_q == HEADER) begin
                        p_state_d = P_WAIT_MODE;
                    end
                end
                P_WAIT_MODE: begin
                    held_d    = shift_q;
                    p_state_d = P_WAIT_CHK;
                end
                P_WAIT_CHK: begin
                    if (shift_q == (HEADER ^ held_q)) begin
                        mode_d       = held_q;
                        mode_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    p_state_d = P_WAIT_HDR;
                end
                default: begin
                    p_state_d = P_WAIT_HDR;
                end
            endcase
        end
    end

    assign modo_operacao = mode_q;
    assign mode_valid    = mode_valid_q;
    assign frame_err     = frame_err_q;
    assign rx_busy       = (rx_state_q != RX_IDLE);

endmodule
`default_nettype wire
